spi_slave_frame_sched: RTL and testbench

- Transaction scheduler in front of the SPI-slave shift engine.
- Buffers CPU-supplied TX words and captured RX words in small FIFOs.
- Arms the shift engine with one 32-bit word per CS frame, and collects the received word when the frame ends.
- Exposes status, error flags and control over the icosoc ctrl bus, so CPU accesses complete in fixed latency and never wait on SPI frames.

---
 rtl/spi_slave_pkg.sv | 37 +++
 rtl/spi_sched_fifo.sv | 86 ++++++++
 rtl/spi_slave_frame_sched.sv | 261 ++++++++++++++++++++++++++
 tb/tb_spi_slave_frame_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg
// Shared definitions for the SPI-slave frame scheduler: bus register
// addresses, STATUS/CTRL bit positions and the scheduler FSM states.
// This package has no ports. It is imported by spi_slave_frame_sched.

package spi_slave_pkg;

    // Register map offsets on the icosoc ctrl bus
    localparam logic [7:0] ADDR_STATUS = 8'h00;
    localparam logic [7:0] ADDR_TXDATA = 8'h04;
    localparam logic [7:0] ADDR_RXDATA = 8'h08;
    localparam logic [7:0] ADDR_CTRL   = 8'h0C;

    // STATUS register layout
    localparam int ST_ARMED     = 0;
    localparam int ST_UNDERRUN  = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_ABORTED   = 3;
    localparam int ST_TXCNT_LSB = 8;
    localparam int ST_RXCNT_LSB = 16;
    localparam int CNT_FIELD_W  = 4;

    // CTRL register layout; CLEAR and FLUSH are write-only strobes
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_RX_IE  = 1;
    localparam int CTRL_ERR_IE = 2;
    localparam int CTRL_CLEAR  = 8;
    localparam int CTRL_FLUSH  = 9;

    // Frame scheduler states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ARMED = 2'd2
    } sched_state_t;

endpackage

// File: rtl/spi_sched_fifo.sv
// spi_sched_fifo
// Small synchronous FIFO used for both the TX and RX word queues of the
// frame scheduler. A simultaneous push and pop both succeed, so a full
// FIFO can accept a push in the same cycle it is popped. A pop of an
// empty FIFO is ignored. Flush empties the FIFO; a push in the same
// cycle lands in the freshly emptied FIFO.
//
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   flush        discard all entries
//   push         write push_data (ignored when full and not popping)
//   push_data    word to write
//   pop          advance past the head entry (ignored when empty)
//   head         oldest entry, meaningful when empty=0
//   count        number of stored entries, 0..DEPTH
//   full, empty  count==DEPTH, count==0

module spi_sched_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, which is what lets a full FIFO
    // take a push while being popped.
    always_comb begin
        do_pop  = pop & ~empty & ~flush;
        do_push = push & (~full | do_pop | flush);
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage needs no reset; entries are only visible once counted
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[flush ? '0 : wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/spi_slave_frame_sched.sv
// spi_slave_frame_sched
// Transaction scheduler in front of the SPI-slave shift engine. The CPU
// queues TX words and drains RX words through the ctrl bus; the
// scheduler arms the engine with one 32-bit word per CS frame and
// collects the received word when the frame ends. Every bus access
// completes one cycle after it is seen, independent of SPI activity.
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   ctrl_wr, ctrl_rd        level bus strobes, held until ctrl_done
//   ctrl_addr, ctrl_wdat    register address and write data
//   ctrl_rdat, ctrl_done    read data and one-cycle completion pulse
//   eng_load, eng_txword    arm pulse and word for the shift engine
//   eng_done, eng_rxword    frame complete pulse and received word
//   eng_abort               CS released before 32 bits were shifted
//   irq                     level interrupt (RX data and/or errors)

module spi_slave_frame_sched
    import spi_slave_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] DUMMY_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ctrl_wr,
    input  logic        ctrl_rd,
    input  logic [7:0]  ctrl_addr,
    input  logic [31:0] ctrl_wdat,
    output logic [31:0] ctrl_rdat,
    output logic        ctrl_done,
    output logic        eng_load,
    output logic [31:0] eng_txword,
    input  logic        eng_done,
    input  logic [31:0] eng_rxword,
    input  logic        eng_abort,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sched_state_t state;
    sched_state_t next_state;

    logic          enable;
    logic          rx_ie;
    logic          err_ie;
    logic          underrun;
    logic          overrun;
    logic          aborted;
    logic          pending_underrun;
    logic [31:0]   txword_q;
    logic [31:0]   load_word;

    logic [31:0]   tx_head;
    logic [31:0]   rx_head;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_empty;

    logic          accept;
    logic          wr_acc;
    logic          rd_acc;
    logic          ctrl_write;
    logic          tx_push;
    logic          tx_pop;
    logic          rx_push;
    logic          rx_pop;
    logic          flush;
    logic          clear;
    logic          set_underrun;
    logic          set_overrun;
    logic          set_aborted;
    logic          armed;
    logic          load;
    logic          frame_end;
    logic [31:0]   status_word;
    logic [31:0]   ctrl_word;
    logic [31:0]   read_value;

    // Bus decode. Nothing is accepted while ctrl_done is high, so a strobe
    // still held during the completion cycle is not executed twice.
    always_comb begin
        accept     = (ctrl_wr | ctrl_rd) & ~ctrl_done;
        wr_acc     = accept & ctrl_wr;
        rd_acc     = accept & ~ctrl_wr & ctrl_rd;
        ctrl_write = wr_acc & (ctrl_addr == ADDR_CTRL);
        tx_push    = wr_acc & (ctrl_addr == ADDR_TXDATA);
        rx_pop     = rd_acc & (ctrl_addr == ADDR_RXDATA);
        clear      = ctrl_write & ctrl_wdat[CTRL_CLEAR];
        flush      = ctrl_write & ctrl_wdat[CTRL_FLUSH];
    end

    spi_sched_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .push      (tx_push),
        .push_data (ctrl_wdat),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    spi_sched_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .push      (rx_push),
        .push_data (eng_rxword),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Scheduler state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Scheduler next state. Once armed the frame must run to done or abort
    // because the SPI master cannot be stopped; enable is only looked at
    // in IDLE.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        armed      = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                load       = 1'b1;
                next_state = S_ARMED;
            end
            S_ARMED: begin
                armed = 1'b1;
                if (eng_done || eng_abort) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Engine-side datapath. eng_done wins over a coincident eng_abort.
    always_comb begin
        load_word   = tx_empty ? DUMMY_WORD : tx_head;
        eng_load    = load;
        eng_txword  = load ? load_word : txword_q;
        tx_pop      = load;
        rx_push     = armed & eng_done;
        frame_end   = armed & (eng_done | eng_abort);
        set_aborted = armed & eng_abort & ~eng_done;
        set_underrun = rx_push & pending_underrun;
        set_overrun  = (tx_push & tx_full & ~tx_pop & ~flush)
                     | (rx_push & rx_full & ~rx_pop & ~flush);
    end

    // Underrun is only reported when a frame built on the dummy word
    // actually completes, so the marker is remembered from LOAD until
    // the frame ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            txword_q         <= '0;
            pending_underrun <= 1'b0;
        end else if (load) begin
            txword_q         <= load_word;
            pending_underrun <= tx_empty;
        end else if (frame_end) begin
            pending_underrun <= 1'b0;
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            underrun <= set_underrun | (underrun & ~clear);
            overrun  <= set_overrun  | (overrun  & ~clear);
            aborted  <= set_aborted  | (aborted  & ~clear);
        end
    end

    // CTRL register bits that persist
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable <= 1'b0;
            rx_ie  <= 1'b0;
            err_ie <= 1'b0;
        end else if (ctrl_write) begin
            enable <= ctrl_wdat[CTRL_ENABLE];
            rx_ie  <= ctrl_wdat[CTRL_RX_IE];
            err_ie <= ctrl_wdat[CTRL_ERR_IE];
        end
    end

    // Read mux; RXDATA on an empty FIFO returns the dummy word silently
    always_comb begin
        status_word = '0;
        status_word[ST_ARMED]    = armed;
        status_word[ST_UNDERRUN] = underrun;
        status_word[ST_OVERRUN]  = overrun;
        status_word[ST_ABORTED]  = aborted;
        status_word[ST_TXCNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(tx_count);
        status_word[ST_RXCNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(rx_count);

        ctrl_word = '0;
        ctrl_word[CTRL_ENABLE] = enable;
        ctrl_word[CTRL_RX_IE]  = rx_ie;
        ctrl_word[CTRL_ERR_IE] = err_ie;

        case (ctrl_addr)
            ADDR_STATUS: read_value = status_word;
            ADDR_RXDATA: read_value = rx_empty ? DUMMY_WORD : rx_head;
            ADDR_CTRL:   read_value = ctrl_word;
            default:     read_value = '0;
        endcase
    end

    // Bus response: one-cycle completion pulse with registered read data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_done <= 1'b0;
            ctrl_rdat <= '0;
        end else begin
            ctrl_done <= accept;
            if (accept) begin
                ctrl_rdat <= rd_acc ? read_value : '0;
            end
        end
    end

    assign irq = ((rx_count != '0) & rx_ie)
               | ((underrun | overrun | aborted) & err_ie);

endmodule

// File: tb/tb_spi_slave_frame_sched.sv
// tb_spi_slave_frame_sched
// Self-checking bench for spi_slave_frame_sched. The bench plays both the
// CPU on the ctrl bus and the SPI shift engine, and keeps a queue-based
// model of the TX/RX FIFOs, flags and control bits.

module tb_spi_slave_frame_sched;

    localparam int          DEPTH = 4;
    localparam logic [31:0] DUMMY = 32'hDEAD_BEEF;

    localparam logic [7:0] A_STATUS = 8'h00;
    localparam logic [7:0] A_TXDATA = 8'h04;
    localparam logic [7:0] A_RXDATA = 8'h08;
    localparam logic [7:0] A_CTRL   = 8'h0C;

    logic        clk;
    logic        resetn;
    logic        ctrl_wr;
    logic        ctrl_rd;
    logic [7:0]  ctrl_addr;
    logic [31:0] ctrl_wdat;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;
    logic        eng_load;
    logic [31:0] eng_txword;
    logic        eng_done;
    logic [31:0] eng_rxword;
    logic        eng_abort;
    logic        irq;

    int total_count = 0;
    int bad_count   = 0;

    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic [31:0] loadq[$];
    bit m_enable, m_rxie, m_errie;
    bit m_under, m_over, m_abort;
    bit m_armed, m_pending;

    spi_slave_frame_sched #(
        .FIFO_DEPTH (DEPTH),
        .DUMMY_WORD (DUMMY)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ctrl_wr    (ctrl_wr),
        .ctrl_rd    (ctrl_rd),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdat  (ctrl_wdat),
        .ctrl_rdat  (ctrl_rdat),
        .ctrl_done  (ctrl_done),
        .eng_load   (eng_load),
        .eng_txword (eng_txword),
        .eng_done   (eng_done),
        .eng_rxword (eng_rxword),
        .eng_abort  (eng_abort),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every engine arm pulse is recorded so sequential code never misses one
    always @(negedge clk) begin
        if (resetn && eng_load) begin
            loadq.push_back(eng_txword);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_count++;
        if (got !== exp) begin
            bad_count++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {12'h0, 4'(rxq.size()), 4'h0, 4'(txq.size()), 4'h0,
                m_abort, m_over, m_under, m_armed};
    endfunction

    function automatic bit exp_irq();
        return ((rxq.size() != 0) && m_rxie) || ((m_under || m_over || m_abort) && m_errie);
    endfunction

    function automatic logic [31:0] ctrl_bits(input bit en, input bit clr, input bit fl);
        return {22'h0, fl, clr, 5'h0, m_errie, m_rxie, en};
    endfunction

    function automatic bit is_mapped(input logic [7:0] a);
        return (a == A_STATUS) || (a == A_TXDATA) || (a == A_RXDATA) || (a == A_CTRL);
    endfunction

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        loadq.delete();
        m_enable = 0; m_rxie = 0; m_errie = 0;
        m_under = 0; m_over = 0; m_abort = 0;
        m_armed = 0; m_pending = 0;
    endtask

    task automatic model_tx_push(input logic [31:0] d);
        if (txq.size() >= DEPTH) m_over = 1;
        else txq.push_back(d);
    endtask

    task automatic busAccess(input bit is_wr, input logic [7:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata);
        int waited;
        @(negedge clk);
        ctrl_wr   = is_wr;
        ctrl_rd   = !is_wr;
        ctrl_addr = addr;
        ctrl_wdat = wdata;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ctrl_done && waited < 10);
        checkOutput("bus_latency", 32'(waited), 32'd1);
        rdata   = ctrl_rdat;
        ctrl_wr = 1'b0;
        ctrl_rd = 1'b0;
    endtask

    task automatic cpuWrite(input logic [7:0] addr, input logic [31:0] data);
        logic [31:0] unused_rd;
        busAccess(1'b1, addr, data, unused_rd);
        if (addr == A_TXDATA) begin
            model_tx_push(data);
        end else if (addr == A_CTRL) begin
            m_enable = data[0];
            m_rxie   = data[1];
            m_errie  = data[2];
            if (data[8]) begin
                m_under = 0; m_over = 0; m_abort = 0;
            end
            if (data[9]) begin
                txq.delete();
                rxq.delete();
            end
        end
    endtask

    task automatic cpuRead(input logic [7:0] addr, input string tag);
        logic [31:0] got;
        logic [31:0] exp;
        busAccess(1'b0, addr, 32'h0, got);
        if (addr == A_STATUS) begin
            exp = exp_status();
        end else if (addr == A_RXDATA) begin
            exp = (rxq.size() != 0) ? rxq.pop_front() : DUMMY;
        end else if (addr == A_CTRL) begin
            exp = {29'h0, m_errie, m_rxie, m_enable};
        end else begin
            exp = 32'h0;
        end
        checkOutput(tag, got, exp);
        if (addr == A_STATUS) begin
            checkOutput({tag, "_irq"}, 32'(irq), 32'(exp_irq()));
        end
    endtask

    // Expected word for the next arm, consuming the model TX queue
    task automatic model_load(output logic [31:0] exp);
        if (txq.size() != 0) begin
            exp = txq.pop_front();
            m_pending = 0;
        end else begin
            exp = DUMMY;
            m_pending = 1;
        end
        m_armed = 1;
    endtask

    task automatic waitLoad(input logic [31:0] exp);
        int waited = 0;
        while (loadq.size() == 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (loadq.size() == 0) checkOutput("load_timeout", 32'd0, 32'd1);
        else checkOutput("eng_txword", loadq.pop_front(), exp);
    endtask

    task automatic endFrame(input bit d, input bit a, input logic [31:0] rx);
        @(negedge clk);
        eng_done   = d;
        eng_abort  = a;
        eng_rxword = rx;
        @(negedge clk);
        eng_done  = 1'b0;
        eng_abort = 1'b0;
        if (d) begin
            if (rxq.size() >= DEPTH) m_over = 1;
            else rxq.push_back(rx);
            if (m_pending) m_under = 1;
        end else if (a) begin
            m_abort = 1;
        end
        if (d || a) begin
            m_pending = 0;
            m_armed   = 0;
        end
    endtask

    // One complete frame: arm, drop enable while armed, finish the frame
    task automatic runFrame(input bit d, input bit a, input logic [31:0] rx, input bit flush_mid);
        logic [31:0] exp;
        model_load(exp);
        cpuWrite(A_CTRL, ctrl_bits(1'b1, 1'b0, 1'b0));
        waitLoad(exp);
        cpuWrite(A_CTRL, ctrl_bits(1'b0, 1'b0, flush_mid));
        cpuRead(A_STATUS, "status_armed");
        endFrame(d, a, rx);
        repeat (3) @(posedge clk);
        checkOutput("extra_load", 32'(loadq.size()), 32'd0);
    endtask

    task automatic applyStimulus(input int op);
        logic [7:0] a;
        int r;
        case (op)
            0, 1: cpuWrite(A_TXDATA, $urandom);
            2: cpuRead(A_RXDATA, "rnd_rxdata");
            3: cpuRead(A_STATUS, "rnd_status");
            4: begin
                r = $urandom_range(0, 5);
                runFrame(r != 4, r >= 4, $urandom, $urandom_range(0, 7) == 0);
            end
            5: cpuWrite(A_CTRL, {22'h0, 1'($urandom_range(0, 7) == 0),
                                 1'($urandom_range(0, 3) == 0), 5'h0,
                                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0});
            6: cpuRead(A_CTRL, "rnd_ctrl");
            default: begin
                do a = 8'($urandom); while (is_mapped(a));
                if ($urandom_range(0, 1) == 1) cpuWrite(a, $urandom);
                else cpuRead(a, "unmapped_read");
            end
        endcase
    endtask

    initial begin
        logic [31:0] exp;
        int gap;

        resetn = 1'b0;
        ctrl_wr = 1'b0; ctrl_rd = 1'b0; ctrl_addr = 8'h0; ctrl_wdat = 32'h0;
        eng_done = 1'b0; eng_abort = 1'b0; eng_rxword = 32'h0;
        model_reset();

        #7;
        checkOutput("rst_rdat", ctrl_rdat, 32'h0);
        checkOutput("rst_done", 32'(ctrl_done), 32'd0);
        checkOutput("rst_load", 32'(eng_load), 32'd0);
        checkOutput("rst_txword", eng_txword, 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cpuRead(A_STATUS, "status_after_reset");

        // Two queued words go out in order, RX comes back in order
        cpuWrite(A_TXDATA, 32'hA5A5_0001);
        cpuWrite(A_TXDATA, 32'hA5A5_0002);
        runFrame(1'b1, 1'b0, 32'h11, 1'b0);
        runFrame(1'b1, 1'b0, 32'h22, 1'b0);
        cpuRead(A_RXDATA, "rx_first");
        cpuRead(A_RXDATA, "rx_second");
        cpuRead(A_STATUS, "status_clean");

        // Empty TX at arm time: dummy word and underrun, then clear
        runFrame(1'b1, 1'b0, 32'h3333, 1'b0);
        cpuRead(A_STATUS, "status_underrun");
        cpuWrite(A_CTRL, ctrl_bits(1'b0, 1'b1, 1'b0));
        cpuRead(A_STATUS, "status_cleared");
        cpuRead(A_RXDATA, "rx_underrun_frame");
        cpuRead(A_RXDATA, "rx_empty_dummy");

        // RX overflow on the fifth frame
        for (int i = 1; i <= 4; i++) runFrame(1'b1, 1'b0, 32'h100 + 32'(i), 1'b0);
        runFrame(1'b1, 1'b0, 32'h55, 1'b0);
        cpuRead(A_STATUS, "status_rx_overrun");
        cpuRead(A_RXDATA, "rx_oldest_kept");
        cpuWrite(A_CTRL, ctrl_bits(1'b0, 1'b1, 1'b1));
        cpuRead(A_STATUS, "status_flushed");

        // Abort with enable held: flag set, re-arm two cycles later
        cpuWrite(A_TXDATA, 32'hAB00_0001);
        model_load(exp);
        cpuWrite(A_CTRL, ctrl_bits(1'b1, 1'b0, 1'b0));
        waitLoad(exp);
        @(negedge clk);
        eng_abort = 1'b1;
        @(negedge clk);
        eng_abort = 1'b0;
        m_abort = 1; m_pending = 0; m_armed = 0;
        gap = 1;
        while (!eng_load && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        checkOutput("reload_gap", 32'(gap), 32'd2);
        model_load(exp);
        waitLoad(exp);
        cpuWrite(A_CTRL, ctrl_bits(1'b0, 1'b0, 1'b0));
        cpuRead(A_STATUS, "status_aborted");
        endFrame(1'b1, 1'b0, 32'h77);
        repeat (3) @(posedge clk);
        checkOutput("extra_load_abort", 32'(loadq.size()), 32'd0);

        // A strobe held through the completion cycle executes once
        @(negedge clk);
        ctrl_wr = 1'b1; ctrl_addr = A_TXDATA; ctrl_wdat = 32'hC0DE_0001;
        @(negedge clk);
        checkOutput("held_done_high", 32'(ctrl_done), 32'd1);
        @(negedge clk);
        checkOutput("held_done_low", 32'(ctrl_done), 32'd0);
        ctrl_wr = 1'b0;
        model_tx_push(32'hC0DE_0001);
        cpuRead(A_STATUS, "status_held_push");

        // Full TX pushed in the same cycle LOAD pops it: no overrun
        cpuWrite(A_CTRL, ctrl_bits(1'b0, 1'b1, 1'b1));
        for (int i = 0; i < DEPTH; i++) cpuWrite(A_TXDATA, 32'hF000_0000 + 32'(i));
        cpuRead(A_STATUS, "status_tx_full");
        exp = txq.pop_front();
        m_pending = 0;
        m_armed = 1;
        cpuWrite(A_CTRL, ctrl_bits(1'b1, 1'b0, 1'b0));
        cpuWrite(A_TXDATA, 32'hF000_00AA);
        waitLoad(exp);
        cpuWrite(A_CTRL, ctrl_bits(1'b0, 1'b0, 1'b0));
        cpuRead(A_STATUS, "status_push_pop_full");
        endFrame(1'b1, 1'b0, 32'h88);

        // Asynchronous reset while armed
        cpuWrite(A_CTRL, {29'h0, 1'b1, 1'b1, 1'b0});
        model_load(exp);
        cpuWrite(A_CTRL, ctrl_bits(1'b1, 1'b0, 1'b0));
        waitLoad(exp);
        cpuRead(A_STATUS, "status_before_reset");
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_rst_rdat", ctrl_rdat, 32'h0);
        checkOutput("async_rst_done", 32'(ctrl_done), 32'd0);
        checkOutput("async_rst_load", 32'(eng_load), 32'd0);
        checkOutput("async_rst_txword", eng_txword, 32'h0);
        checkOutput("async_rst_irq", 32'(irq), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cpuRead(A_STATUS, "status_post_reset");
        repeat (10) @(posedge clk);
        checkOutput("no_load_after_reset", 32'(loadq.size()), 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 200; i++) begin
            applyStimulus(int'($urandom_range(0, 7)));
        end
        cpuRead(A_STATUS, "status_final");

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
